// File: rtl/axi4_lite_initiator_if.sv
// Bundle of the command/response bus and the AXI4-Lite master channels
// used by axi4_lite_initiator. The master modport is the initiator's view;
// the slave modport is the view of whatever sits on the other side
// (command source, response sink and AXI4-Lite register slave).
interface axi4_lite_initiator_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    // Simple command/response bus
    logic                  cmdValid;
    logic                  cmdReady;
    logic                  cmdWr;
    logic [ADDR_WIDTH-1:0] cmdAddr;
    logic [DATA_WIDTH-1:0] cmdWrData;
    logic [3:0]            cmdWrStrb;
    logic                  rspValid;
    logic                  rspReady;
    logic                  rspWr;
    logic [DATA_WIDTH-1:0] rspData;
    logic [1:0]            rspResp;

    // AXI4-Lite write address / data / response channels
    logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0] M_AXI_WDATA;
    logic [3:0]            M_AXI_WSTRB;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;

    // AXI4-Lite read address / data channels
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        input  cmdValid, cmdWr, cmdAddr, cmdWrData, cmdWrStrb, rspReady,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output cmdReady, rspValid, rspWr, rspData, rspResp,
        output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
    );

    modport slave (
        output cmdValid, cmdWr, cmdAddr, cmdWrData, cmdWrStrb, rspReady,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  cmdReady, rspValid, rspWr, rspData, rspResp,
        input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
    );
endinterface

// File: rtl/axi4_lite_initiator.sv
// AXI4-Lite master: turns single-beat commands from a simple valid/ready
// bus into AXI4-Lite read or write transactions, one at a time, and hands
// the result back on a held response port. Every AXI output and every
// response output comes straight from a register.
//
// Optional feature: define AXI_INIT_TIMEOUT_EN to add a per-transaction
// busy-cycle watchdog and the sticky `timeout` output.
module axi4_lite_initiator #(
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                         M_AXI_ACLK,
    input  logic                         M_AXI_ARESET,
    axi4_lite_initiator_if.master        bus
`ifdef AXI_INIT_TIMEOUT_EN
    ,
    output logic                         timeout
`endif
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    // All registered outputs plus the two write-handshake flags. The AXI
    // address/data registers double as the command latch: they hold the
    // command while VALID is high and read as zero otherwise.
    typedef struct packed {
        logic          cmd_ready;
        logic          aw_valid;
        logic [AW-1:0] aw_addr;
        logic          w_valid;
        logic [DW-1:0] w_data;
        logic [3:0]    w_strb;
        logic          aw_done;
        logic          w_done;
        logic          b_ready;
        logic          ar_valid;
        logic [AW-1:0] ar_addr;
        logic          r_ready;
        logic          rsp_valid;
        logic          rsp_wr;
        logic [DW-1:0] rsp_data;
        logic [1:0]    rsp_resp;
    } regs_t;

    state_t state_q, state_d;
    regs_t  regs_q, regs_d;

    logic cmd_fire;
    logic aw_hs;
    logic w_hs;

    assign cmd_fire = bus.cmdValid && regs_q.cmd_ready;
    assign aw_hs    = regs_q.aw_valid && bus.M_AXI_AWREADY;
    assign w_hs     = regs_q.w_valid  && bus.M_AXI_WREADY;

    // State and output registers; reset clears everything, even mid-transaction
    always_ff @(posedge M_AXI_ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (M_AXI_ARESET) begin
            state_q <= IDLE;
            regs_q  <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        // NOTE: every target gets a default (hold) first, so no branch can
        // leave a signal unassigned and infer a latch.
        state_d = state_q;
        regs_d  = regs_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    regs_d.cmd_ready = 1'b0;
                    if (bus.cmdWr) begin
                        state_d         = WR_REQ;
                        regs_d.aw_valid = 1'b1;
                        regs_d.aw_addr  = bus.cmdAddr;
                        regs_d.w_valid  = 1'b1;
                        regs_d.w_data   = bus.cmdWrData;
                        regs_d.w_strb   = bus.cmdWrStrb;
                        regs_d.aw_done  = 1'b0;
                        regs_d.w_done   = 1'b0;
                    end else begin
                        state_d         = RD_REQ;
                        regs_d.ar_valid = 1'b1;
                        regs_d.ar_addr  = bus.cmdAddr;
                    end
                end else begin
                    // Also raises cmdReady on the first cycle out of reset.
                    regs_d.cmd_ready = 1'b1;
                end
            end

            WR_REQ: begin
                // AW and W complete independently; each VALID drops on its own.
                if (aw_hs) begin
                    regs_d.aw_valid = 1'b0;
                    regs_d.aw_addr  = '0;
                    regs_d.aw_done  = 1'b1;
                end
                if (w_hs) begin
                    regs_d.w_valid = 1'b0;
                    regs_d.w_data  = '0;
                    regs_d.w_strb  = '0;
                    regs_d.w_done  = 1'b1;
                end
                if (regs_d.aw_done && regs_d.w_done) begin
                    state_d        = WR_RESP;
                    regs_d.b_ready = 1'b1;
                end
            end

            WR_RESP: begin
                if (bus.M_AXI_BVALID) begin
                    state_d          = RSP;
                    regs_d.b_ready   = 1'b0;
                    regs_d.rsp_valid = 1'b1;
                    regs_d.rsp_wr    = 1'b1;
                    regs_d.rsp_data  = '0;
                    regs_d.rsp_resp  = bus.M_AXI_BRESP;
                end
            end

            RD_REQ: begin
                if (bus.M_AXI_ARREADY) begin
                    state_d         = RD_DATA;
                    regs_d.ar_valid = 1'b0;
                    regs_d.ar_addr  = '0;
                    regs_d.r_ready  = 1'b1;
                end
            end

            RD_DATA: begin
                if (bus.M_AXI_RVALID) begin
                    state_d          = RSP;
                    regs_d.r_ready   = 1'b0;
                    regs_d.rsp_valid = 1'b1;
                    regs_d.rsp_wr    = 1'b0;
                    regs_d.rsp_data  = bus.M_AXI_RDATA;
                    regs_d.rsp_resp  = bus.M_AXI_RRESP;
                end
            end

            RSP: begin
                // Response is held untouched until the consumer takes it.
                if (bus.rspReady) begin
                    state_d          = IDLE;
                    regs_d.rsp_valid = 1'b0;
                    regs_d.cmd_ready = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                regs_d  = '0;
            end
        endcase
    end

`ifdef AXI_INIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_active;

    // Only cycles spent waiting on the slave count toward the limit.
    assign wd_active = (state_q != IDLE) && (state_q != RSP);

    // Watchdog: count busy cycles per transaction; flag sticks until reset
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state_d == IDLE) begin
                wd_cnt <= '0;
            end else if (wd_active && wd_cnt != LIMIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_active && wd_cnt == LIMIT - 1'b1) begin
                timeout <= 1'b1;
            end
        end
    end
`endif

    assign bus.cmdReady      = regs_q.cmd_ready;
    assign bus.rspValid      = regs_q.rsp_valid;
    assign bus.rspWr         = regs_q.rsp_wr;
    assign bus.rspData       = regs_q.rsp_data;
    assign bus.rspResp       = regs_q.rsp_resp;
    assign bus.M_AXI_AWADDR  = regs_q.aw_addr;
    assign bus.M_AXI_AWVALID = regs_q.aw_valid;
    assign bus.M_AXI_WDATA   = regs_q.w_data;
    assign bus.M_AXI_WSTRB   = regs_q.w_strb;
    assign bus.M_AXI_WVALID  = regs_q.w_valid;
    assign bus.M_AXI_BREADY  = regs_q.b_ready;
    assign bus.M_AXI_ARADDR  = regs_q.ar_addr;
    assign bus.M_AXI_ARVALID = regs_q.ar_valid;
    assign bus.M_AXI_RREADY  = regs_q.r_ready;

endmodule

// File: tb/tb_axi4_lite_initiator.sv
// Self-checking bench for axi4_lite_initiator: a directed vector table,
// hand-written reset and watchdog sequences, and randomized transactions
// scored against a register-file model with a closed-form latency rule.
module tb_axi4_lite_initiator;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_lite_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef AXI_INIT_TIMEOUT_EN
    logic timeout;
`endif

    axi4_lite_initiator #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESET(rst),
        .bus(bus)
`ifdef AXI_INIT_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    strb;
        int            aw_w, w_w, b_w, ar_w, r_w;
        logic [1:0]    resp;
        int            hold;
    } txn_t;

    typedef struct {
        txn_t          t;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_resp;
        int            exp_cycle;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_mem [16];
    logic [DW-1:0] slave_mem [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [3:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic txn_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic [3:0] strb, input int aw_w, input int w_w, input int b_w,
                                input int ar_w, input int r_w, input logic [1:0] resp, input int hold);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data; t.strb = strb;
        t.aw_w = aw_w; t.w_w = w_w; t.b_w = b_w; t.ar_w = ar_w; t.r_w = r_w;
        t.resp = resp; t.hold = hold;
        return t;
    endfunction

    function automatic logic any_output();
        return |{bus.cmdReady, bus.rspValid, bus.rspWr, bus.rspData, bus.rspResp,
                 bus.M_AXI_AWVALID, bus.M_AXI_AWADDR, bus.M_AXI_WVALID, bus.M_AXI_WDATA,
                 bus.M_AXI_WSTRB, bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_ARADDR,
                 bus.M_AXI_RREADY};
    endfunction

    task automatic cmd_idle();
        bus.cmdValid = 1'b0; bus.cmdWr = 1'b0; bus.cmdAddr = '0;
        bus.cmdWrData = '0; bus.cmdWrStrb = '0;
    endtask

    task automatic slave_idle();
        bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
        bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = '0;
        bus.M_AXI_ARREADY = 1'b0;
        bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RDATA = '0; bus.M_AXI_RRESP = '0;
    endtask

    // One full transaction: command, reactive slave, response hand-off.
    task automatic run_txn(input txn_t t, input logic [DW-1:0] exp_data, input logic [1:0] exp_resp,
                           input int exp_cycle, input string tag);
        int waited, aw_hi, w_hi, ar_hi, aw_c, w_c, ar_c, b_c, r_c, rsp_c;
        logic ok;
        logic [AW-1:0] s_waddr, s_raddr;
        logic [DW-1:0] s_wdata;
        logic [3:0]    s_wstrb;
        logic          snap_wr;
        logic [DW-1:0] snap_data;
        logic [1:0]    snap_resp;

        waited = 0;
        @(negedge clk);
        while (!bus.cmdReady && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " cmd_ready_before"}, 64'(bus.cmdReady), 64'(1));

        bus.cmdValid = 1'b1; bus.cmdWr = t.wr; bus.cmdAddr = t.addr;
        bus.cmdWrData = t.data; bus.cmdWrStrb = t.strb;

        aw_hi = 0; w_hi = 0; ar_hi = 0;
        aw_c = -1; w_c = -1; ar_c = -1; b_c = -1; r_c = -1; rsp_c = -1;
        ok = 1'b1;
        s_waddr = '0; s_raddr = '0; s_wdata = '0; s_wstrb = '0;

        for (int cyc = 1; cyc <= 40 && rsp_c < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) cmd_idle();

            // Observe what the initiator presents this cycle
            if (bus.cmdReady) ok = 1'b0;
            if (bus.M_AXI_AWVALID) begin
                aw_hi++;
                if (bus.M_AXI_AWADDR !== t.addr) ok = 1'b0;
            end else if (bus.M_AXI_AWADDR !== '0) ok = 1'b0;
            if (bus.M_AXI_WVALID) begin
                w_hi++;
                if (bus.M_AXI_WDATA !== t.data || bus.M_AXI_WSTRB !== t.strb) ok = 1'b0;
            end else if (bus.M_AXI_WDATA !== '0 || bus.M_AXI_WSTRB !== '0) ok = 1'b0;
            if (bus.M_AXI_ARVALID) begin
                ar_hi++;
                if (bus.M_AXI_ARADDR !== t.addr) ok = 1'b0;
            end else if (bus.M_AXI_ARADDR !== '0) ok = 1'b0;
            if (bus.M_AXI_BREADY && (aw_c < 0 || w_c < 0)) ok = 1'b0;
            if (bus.rspValid) rsp_c = cyc;

            // Slave reaction for this cycle
            bus.M_AXI_AWREADY = t.wr && aw_c < 0 && cyc >= 1 + t.aw_w;
            bus.M_AXI_WREADY  = t.wr && w_c < 0 && cyc >= 1 + t.w_w;
            bus.M_AXI_ARREADY = !t.wr && ar_c < 0 && cyc >= 1 + t.ar_w;
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
                aw_c = cyc; s_waddr = bus.M_AXI_AWADDR;
            end
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                w_c = cyc; s_wdata = bus.M_AXI_WDATA; s_wstrb = bus.M_AXI_WSTRB;
            end
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                ar_c = cyc; s_raddr = bus.M_AXI_ARADDR;
            end

            bus.M_AXI_BVALID = aw_c > 0 && w_c > 0 && b_c < 0 &&
                               cyc >= (aw_c > w_c ? aw_c : w_c) + 1 + t.b_w;
            bus.M_AXI_BRESP  = bus.M_AXI_BVALID ? t.resp : 2'b00;
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
                b_c = cyc;
                slave_mem[s_waddr[5:2]] = merge(slave_mem[s_waddr[5:2]], s_wdata, s_wstrb);
            end

            bus.M_AXI_RVALID = ar_c > 0 && r_c < 0 && cyc >= ar_c + 1 + t.r_w;
            bus.M_AXI_RDATA  = bus.M_AXI_RVALID ? slave_mem[s_raddr[5:2]] : '0;
            bus.M_AXI_RRESP  = bus.M_AXI_RVALID ? t.resp : 2'b00;
            if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) r_c = cyc;
        end
        slave_idle();

        check({tag, " rsp_cycle"}, 64'(rsp_c), 64'(exp_cycle));
        check({tag, " rsp_wr"}, 64'(bus.rspWr), 64'(t.wr));
        check({tag, " rsp_data"}, 64'(bus.rspData), 64'(exp_data));
        check({tag, " rsp_resp"}, 64'(bus.rspResp), 64'(exp_resp));
        if (t.wr) begin
            check({tag, " awvalid_cycles"}, 64'(aw_hi), 64'(t.aw_w + 1));
            check({tag, " wvalid_cycles"}, 64'(w_hi), 64'(t.w_w + 1));
        end else begin
            check({tag, " arvalid_cycles"}, 64'(ar_hi), 64'(t.ar_w + 1));
        end

        // Back-pressure: response must stay put, nothing else may move
        snap_wr = bus.rspWr; snap_data = bus.rspData; snap_resp = bus.rspResp;
        for (int h = 0; h < t.hold; h++) begin
            @(negedge clk);
            if (!bus.rspValid || bus.rspWr !== snap_wr || bus.rspData !== snap_data ||
                bus.rspResp !== snap_resp || bus.cmdReady || bus.M_AXI_AWVALID ||
                bus.M_AXI_WVALID || bus.M_AXI_ARVALID || bus.M_AXI_BREADY || bus.M_AXI_RREADY)
                ok = 1'b0;
        end
        bus.rspReady = 1'b1;
        @(negedge clk);
        bus.rspReady = 1'b0;
        check({tag, " cmd_ready_after"}, 64'(bus.cmdReady), 64'(1));
        check({tag, " rsp_released"}, 64'(bus.rspValid), 64'(0));
        check({tag, " protocol"}, 64'(ok), 64'(1));
    endtask

    vec_t          vecs [9];
    txn_t          rt;
    logic [DW-1:0] ed;
    int            ec;
    int            waited;

    initial begin
        cmd_idle();
        slave_idle();
        bus.rspReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = '0;
            slave_mem[i] = '0;
        end

        //                    wr    addr   data           strb aw w  b  ar r  resp  hold
        vecs[0].t = mk(1'b1, 6'h14, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0);
        vecs[1].t = mk(1'b1, 6'h08, 32'h12345678, 4'hF, 3, 0, 0, 0, 0, 2'b00, 0);
        vecs[2].t = mk(1'b0, 6'h08, 32'h0,        4'h0, 0, 0, 0, 0, 2, 2'b10, 0);
        vecs[3].t = mk(1'b0, 6'h14, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 5);
        vecs[4].t = mk(1'b1, 6'h14, 32'h0000AA55, 4'h3, 1, 2, 1, 0, 0, 2'b11, 0);
        vecs[5].t = mk(1'b0, 6'h14, 32'h0,        4'h0, 0, 0, 0, 1, 1, 2'b00, 1);
        vecs[6].t = mk(1'b0, 6'h3C, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b11, 0);
        vecs[7].t = mk(1'b1, 6'h00, 32'h11223344, 4'h8, 0, 1, 2, 0, 0, 2'b10, 2);
        vecs[8].t = mk(1'b0, 6'h00, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0);
        vecs[0].exp_data = 32'h0;        vecs[0].exp_resp = 2'b00; vecs[0].exp_cycle = 3;
        vecs[1].exp_data = 32'h0;        vecs[1].exp_resp = 2'b00; vecs[1].exp_cycle = 6;
        vecs[2].exp_data = 32'h12345678; vecs[2].exp_resp = 2'b10; vecs[2].exp_cycle = 5;
        vecs[3].exp_data = 32'hDEADBEEF; vecs[3].exp_resp = 2'b00; vecs[3].exp_cycle = 3;
        vecs[4].exp_data = 32'h0;        vecs[4].exp_resp = 2'b11; vecs[4].exp_cycle = 6;
        vecs[5].exp_data = 32'hDEADAA55; vecs[5].exp_resp = 2'b00; vecs[5].exp_cycle = 5;
        vecs[6].exp_data = 32'h0;        vecs[6].exp_resp = 2'b11; vecs[6].exp_cycle = 3;
        vecs[7].exp_data = 32'h0;        vecs[7].exp_resp = 2'b10; vecs[7].exp_cycle = 6;
        vecs[8].exp_data = 32'h11000000; vecs[8].exp_resp = 2'b00; vecs[8].exp_cycle = 3;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset outputs_zero", 64'(any_output()), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("reset cmd_ready_rises", 64'(bus.cmdReady), 64'(1));

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].t, vecs[i].exp_data, vecs[i].exp_resp, vecs[i].exp_cycle,
                    $sformatf("vec%0d", i));
            if (vecs[i].t.wr)
                model_mem[vecs[i].t.addr[5:2]] = merge(model_mem[vecs[i].t.addr[5:2]],
                                                       vecs[i].t.data, vecs[i].t.strb);
        end

        // Reset in the middle of a write with AWVALID/WVALID high
        waited = 0;
        @(negedge clk);
        while (!bus.cmdReady && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        bus.cmdValid = 1'b1; bus.cmdWr = 1'b1; bus.cmdAddr = 6'h20;
        bus.cmdWrData = 32'hCAFEF00D; bus.cmdWrStrb = 4'hF;
        @(negedge clk);
        cmd_idle();
        check("rst_mid awvalid_before", 64'(bus.M_AXI_AWVALID), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid outputs_zero", 64'(any_output()), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid cmd_ready", 64'(bus.cmdReady), 64'(1));
        rt = mk(1'b0, 6'h20, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0);
        run_txn(rt, model_mem[8], 2'b00, 3, "rst_mid read");

        // Randomized traffic against the register-file model
        for (int i = 0; i < 40; i++) begin
            rt = mk(1'($urandom_range(1, 0)), 6'($urandom_range(63, 0)), $urandom(),
                    4'($urandom_range(15, 0)), int'($urandom_range(2, 0)),
                    int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                    int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                    2'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
            if (rt.wr) begin
                ed = '0;
                ec = 3 + (rt.aw_w > rt.w_w ? rt.aw_w : rt.w_w) + rt.b_w;
                model_mem[rt.addr[5:2]] = merge(model_mem[rt.addr[5:2]], rt.data, rt.strb);
            end else begin
                ed = model_mem[rt.addr[5:2]];
                ec = 3 + rt.ar_w + rt.r_w;
            end
            run_txn(rt, ed, rt.resp, ec, $sformatf("rand%0d", i));
        end

`ifdef AXI_INIT_TIMEOUT_EN
        // Watchdog: ARREADY held low well past the limit
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("wd timeout_clear", 64'(timeout), 64'(0));
        bus.cmdValid = 1'b1; bus.cmdWr = 1'b0; bus.cmdAddr = 6'h14;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cyc == 1) cmd_idle();
            if (cyc == 8) check("wd before_limit", 64'(timeout), 64'(0));
            if (cyc == 9) check("wd at_limit", 64'(timeout), 64'(1));
            if (cyc == 12) begin
                check("wd arvalid_held", 64'(bus.M_AXI_ARVALID), 64'(1));
                bus.M_AXI_ARREADY = 1'b1;
            end else begin
                bus.M_AXI_ARREADY = 1'b0;
            end
            if (cyc == 13) begin
                bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = slave_mem[5]; bus.M_AXI_RRESP = 2'b00;
            end else begin
                bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RDATA = '0;
            end
            if (cyc == 14) begin
                check("wd rsp_valid", 64'(bus.rspValid), 64'(1));
                check("wd rsp_data", 64'(bus.rspData), 64'(model_mem[5]));
                bus.rspReady = 1'b1;
            end
        end
        @(negedge clk);
        bus.rspReady = 1'b0;
        check("wd cmd_ready", 64'(bus.cmdReady), 64'(1));
        check("wd sticky", 64'(timeout), 64'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
